// File: rtl/priority_pkg.sv
// Shared types for the priority interrupt encoder.
// State encodings and the default channel count.
package priority_pkg;

   localparam int N_CH_DEF = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

endpackage

// File: rtl/encoder_pri_find.sv
// Combinational highest-set-bit search.
// Returns the index of the top set bit and whether any bit is set.
import priority_pkg::*;

module encoder_pri_find #(
   parameter  int N_CH = N_CH_DEF,
   localparam int W    = $clog2(N_CH)
) (
   input  logic [N_CH-1:0] req,
   output logic [W-1:0]    idx,
   output logic            found
);

   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         if (req[i]) begin
            idx   = W'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/priority_irq_encoder.sv
// Edge-captured, acknowledged interrupt priority encoder.
// Define ROTATE_PRI_EN for round-robin priority; otherwise fixed.
import priority_pkg::*;

module priority_irq_encoder #(
   parameter  int N_CH = N_CH_DEF,
   localparam int W    = $clog2(N_CH)
) (
   input  logic            iClk,
   input  logic            iRst,
   input  logic            iEI,
   input  logic [N_CH-1:0] iData,
   input  logic            iAck,
   output logic [W-1:0]    oData,
   output logic            oValid,
   output logic            oEO
);

   state_t          state;
   logic [N_CH-1:0] prev;
   logic [N_CH-1:0] pending;
   logic [N_CH-1:0] pendNext;
   logic [N_CH-1:0] events;
   logic [N_CH-1:0] clrMask;
   logic [N_CH-1:0] rotVec;
   logic [W-1:0]    grantIdx;
   logic [W-1:0]    top;
   logic [W-1:0]    findIdx;
   logic [W-1:0]    winner;
   logic            found;
   logic            ackNow;

   assign ackNow = (state == GRANT) && iAck;
   assign events = prev & ~iData;

   // Set is applied after clear so a same-cycle re-edge keeps the bit.
   always_comb begin
      clrMask = '0;
      clrMask[grantIdx] = ackNow;
      pendNext = (pending & ~clrMask) | events;
   end

   // Rotate so channel 'top' lands in the MSB, search, rotate back.
   always_comb begin
      logic [W-1:0] k;
      rotVec = '0;
      for (int j = 0; j < N_CH; j++) begin
         k = W'(j) + top + W'(1);
         rotVec[j] = pending[k];
      end
   end

   encoder_pri_find #(.N_CH(N_CH)) uFind (
      .req   (rotVec),
      .idx   (findIdx),
      .found (found)
   );

   assign winner = findIdx + top + W'(1);

`ifdef ROTATE_PRI_EN
   always_ff @(posedge iClk) begin
      if (iRst) begin
         top <= '1;
      end else if (ackNow) begin
         top <= grantIdx - W'(1);
      end
   end
`else
   assign top = '1;
`endif

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state    <= IDLE;
         prev     <= '1;
         pending  <= '0;
         grantIdx <= '0;
         oData    <= '1;
         oValid   <= 1'b0;
         oEO      <= 1'b0;
      end else begin
         prev    <= iData;
         pending <= pendNext;
         oEO     <= |pendNext;
         unique case (state)
            IDLE: begin
               if (!iEI && found) begin
                  grantIdx <= winner;
                  oData    <= ~winner;
                  oValid   <= 1'b1;
                  state    <= GRANT;
               end else begin
                  oData  <= '1;
                  oValid <= 1'b0;
               end
            end
            GRANT: begin
               if (iAck) begin
                  oData  <= '1;
                  oValid <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_priority_irq_encoder.sv
// Randomized and directed bench for priority_irq_encoder (N_CH=8).
// Reference model tracks requests as a plain bit array.
module tb_priority_irq_encoder;

   localparam int N = 8;

   logic       clk = 1'b0;
   logic       iRst = 1'b1;
   logic       iEI = 1'b1;
   logic [7:0] iData = 8'hFF;
   logic       iAck = 1'b0;
   logic [2:0] oData;
   logic       oValid;
   logic       oEO;

   int nCmp = 0;
   int nBad = 0;

   bit         mPend [N];
   bit         mPrev [N];
   bit         mBusy;
   int         mWin;
   int         mTop;
   logic [2:0] eData;
   logic       eValid;
   logic       eEO;

   priority_irq_encoder dut (
      .iClk   (clk),
      .iRst   (iRst),
      .iEI    (iEI),
      .iData  (iData),
      .iAck   (iAck),
      .oData  (oData),
      .oValid (oValid),
      .oEO    (oEO)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      nCmp++;
      if (obs !== exp) begin
         nBad++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   function automatic bit anyPend();
      for (int i = 0; i < N; i++) if (mPend[i]) return 1'b1;
      return 1'b0;
   endfunction

   // One clock edge: advance the model with the inputs seen at the edge.
   task automatic modelEdge();
      bit ev [N];
      if (iRst) begin
         for (int i = 0; i < N; i++) begin
            mPend[i] = 1'b0;
            mPrev[i] = 1'b1;
         end
         mBusy = 1'b0; mTop = N - 1;
         eData = 3'b111; eValid = 1'b0; eEO = 1'b0;
         return;
      end
      for (int i = 0; i < N; i++) ev[i] = mPrev[i] && !iData[i];
      if (mBusy && iAck) begin
         mPend[mWin] = 1'b0;
         mBusy = 1'b0;
         eValid = 1'b0; eData = 3'b111;
`ifdef ROTATE_PRI_EN
         mTop = (mWin + N - 1) % N;
`endif
      end else if (!mBusy && !iEI && anyPend()) begin
         for (int k = 0; k < N; k++) begin
            int c;
            c = (mTop - k + N) % N;
            if (mPend[c]) begin
               mWin = c;
               break;
            end
         end
         mBusy = 1'b1;
         eValid = 1'b1;
         eData = 3'(7 - mWin);
      end
      for (int i = 0; i < N; i++) begin
         if (ev[i]) mPend[i] = 1'b1;
         mPrev[i] = iData[i];
      end
      eEO = anyPend();
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      modelEdge();
      #1;
      check({tag, ".valid"}, oValid, eValid);
      check({tag, ".data"}, oData, eData);
      check({tag, ".eo"}, oEO, eEO);
   endtask

   task automatic drive(input logic [7:0] d, input logic ei, input logic ack);
      iData = d; iEI = ei; iAck = ack;
   endtask

   initial begin
      int exp36;
      iRst = 1'b1;
      step("rst");
      check("rstData", oData, 3'b111);
      iRst = 1'b0;
      drive(8'hFF, 1'b0, 1'b0);
      step("idle");

      // Single request on ch5
      drive(8'hDF, 1'b0, 1'b0);
      step("c5a");
      check("c5eo", oEO, 1);
      check("c5nov", oValid, 0);
      step("c5b");
      check("c5v", oValid, 1);
      check("c5d", oData, 3'b010);
      drive(8'hDF, 1'b0, 1'b1);
      step("c5ack");
      check("c5ackV", oValid, 0);
      check("c5ackEO", oEO, 0);

      // ch6 and ch2 together
      drive(8'hFF, 1'b0, 1'b0);
      step("p33a");
      drive(8'hBB, 1'b0, 1'b0);
      step("p33b");
      step("p33c");
      check("g6", oData, 3'b001);
      drive(8'hBB, 1'b0, 1'b1);
      step("p33d");
      check("bubble", oValid, 0);
      drive(8'hBB, 1'b0, 1'b0);
      step("p33e");
      check("g2v", oValid, 1);
      check("g2", oData, 3'b101);
      drive(8'hBB, 1'b0, 1'b1);
      step("p33f");

      // iEI gating on ch3
      drive(8'hFF, 1'b1, 1'b0);
      step("p34a");
      drive(8'hF7, 1'b1, 1'b0);
      step("p34b");
      step("p34c");
      check("eiEO", oEO, 1);
      check("eiBlk", oValid, 0);
      drive(8'hF7, 1'b0, 1'b0);
      step("p34d");
      check("g3", oData, 3'b100);
      drive(8'hF7, 1'b0, 1'b1);
      step("p34e");

      // ch4 re-edge in its own ack cycle
      drive(8'hFF, 1'b0, 1'b0);
      step("p35a");
      drive(8'hEF, 1'b0, 1'b0);
      step("p35b");
      step("p35c");
      check("g4", oData, 3'b011);
      drive(8'hFF, 1'b0, 1'b0);
      step("p35d");
      drive(8'hEF, 1'b0, 1'b1);
      step("p35e");
      check("keepEO", oEO, 1);
      drive(8'hEF, 1'b0, 1'b0);
      step("p35f");
      check("reg4", oData, 3'b011);
      drive(8'hEF, 1'b0, 1'b1);
      step("p35g");

      // ch7 re-edges in its ack cycle with ch6 still pending
      drive(8'hFF, 1'b0, 1'b0);
      step("p36a");
      drive(8'h3F, 1'b0, 1'b0);
      step("p36b");
      step("p36c");
      check("g7", oData, 3'b000);
      drive(8'hFF, 1'b0, 1'b0);
      step("p36d");
      drive(8'h7F, 1'b0, 1'b1);
      step("p36e");
      drive(8'h7F, 1'b0, 1'b0);
      step("p36f");
`ifdef ROTATE_PRI_EN
      exp36 = 1;
`else
      exp36 = 0;
`endif
      check("p36next", oData, exp36);

      // Reset mid-grant
      drive(8'h00, 1'b0, 1'b0);
      iRst = 1'b1;
      step("midRst");
      check("midRstV", oValid, 0);
      check("midRstD", oData, 3'b111);
      check("midRstEO", oEO, 0);
      iRst = 1'b0;

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         logic [7:0] d;
         d = iData;
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(3) == 0) d[i] = ~d[i];
         end
         iData = d;
         iEI = ($urandom_range(3) == 0);
         iAck = $urandom_range(1);
         iRst = ($urandom_range(99) == 0);
         step("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule
